dht11_avg_filter: RTL and testbench
===================================

// Module: dht11_avg_filter
// PURPOSE
//  Sits between the DHT11 reader and its consumers (LCD controller, fan FSM).
//  Range-checks each reading, keeps a DEPTH-deep ring buffer per channel and
//  publishes a moving average of the integer temperature and humidity.
//  Also flags stale data when the sensor stops delivering readings.
// PARAMETERS
//  DEPTH        4            samples averaged; must be a power of 2 (2..16)
//  LOG2_DEPTH   2            log2(DEPTH)
//  T_MIN/T_MAX  0 / 50       accepted temperature range, degC inclusive
//  H_MIN/H_MAX  20 / 90      accepted humidity range, %RH inclusive
//  STALE_CYC    150_000_000  clk cycles with no accepted sample before stale_o
//  SPIKE_TH     5            max |temp_i - temp_o| (used only with spike option)
// PORTS
//  clk           in   1  system clock, 50 MHz
//  rst_n         in   1  asynchronous reset, active low
//  valid_i       in   1  one-cycle pulse; temp_i/hum_i valid on this cycle
//  temp_i        in   8  integer temperature from sensor
//  hum_i         in   8  integer humidity from sensor
//  temp_o        out  8  filtered temperature
//  hum_o         out  8  filtered humidity
//  valid_o       out  1  one-cycle pulse; new temp_o/hum_o
//  full_o        out  1  ring buffer holds DEPTH accepted samples
//  stale_o       out  1  no accepted sample for STALE_CYC cycles
//  reject_cnt_o  out  8  count of rejected samples, saturates at 255
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, buffers/sums/pointers/counters
//    cleared, FSM to S_IDLE. Reset mid-sequence aborts it; no valid_o follows.
//  - FSM: S_IDLE -> S_CHECK -> S_ACCUM -> S_EMIT -> S_IDLE.
//    S_IDLE: on valid_i, latch temp_i/hum_i and go to S_CHECK.
//      valid_i in any other state is ignored (not counted, not stored).
//    S_CHECK: out of range on either channel -> reject_cnt_o+1 (sat 255),
//      go to S_IDLE, no valid_o. Else -> S_ACCUM.
//    S_ACCUM: sum += new - buf[wr_ptr] (buf entry is 0 until first wrap);
//      buf[wr_ptr] = new; wr_ptr = wr_ptr+1 mod DEPTH; count sat at DEPTH.
//    S_EMIT: valid_o=1 for exactly this cycle. If count<DEPTH, temp_o/hum_o =
//      newest sample (pass-through). If count==DEPTH, output sum>>LOG2_DEPTH
//      (truncation). full_o=1 from this cycle once count==DEPTH.
//  - Latency: valid_i in cycle N -> valid_o in cycle N+3. Throughput 1 per 4.
//  - Sums are 8+LOG2_DEPTH bits; no overflow possible. Inputs unsigned.
//  - temp_o/hum_o hold their value between valid_o pulses.
//  - Stale: counter clears on every accepted sample (S_ACCUM), else counts up
//    saturating at STALE_CYC; stale_o=1 while counter==STALE_CYC. Rejected
//    samples do not clear it. stale_o drops in the cycle after S_ACCUM.
//  - Accept and stale-saturation on same cycle: accept wins (counter clears).
// CONFIGURATION
//  DHT11_FILTER_SPIKE_EN defined: in S_CHECK with full_o=1, an in-range sample
//    with |temp_i - temp_o| > SPIKE_TH is rejected as a spike (reject_cnt_o+1).
//    A spike counter tracks consecutive spikes; the 3rd consecutive one is
//    accepted (real step change) and clears it; any accepted sample clears it.
//  Not defined: no spike check; only range check applies.
// TESTING
//  - Reset: rst_n=0 mid-S_ACCUM -> all outputs 0 immediately, no valid_o after.
//  - Fill: temps 20,22,24,26 (hum 50) -> temp_o 20,22,24,26 each N+3;
//    full_o rises with 4th; 5th temp 30 -> temp_o=(22+24+26+30)>>2=25.
//  - Range: temp_i=60 or hum_i=10 -> no valid_o, reject_cnt_o+1;
//    300 rejects -> reject_cnt_o=255.
//  - Back-to-back: valid_i at N and N+1 -> only N processed, one valid_o.
//  - Stale (STALE_CYC=100 in bench): 100 idle cycles -> stale_o=1;
//    next good sample -> stale_o=0.
//  - Spike (macro on): full at 25, feed 40,40,40 -> first two rejected,
//    third accepted; macro off -> all three accepted.

Source files
------------

// File: rtl/dht11_avg_filter.sv
// dht11_avg_filter
//   Filters DHT11 readings before they reach the LCD controller and fan FSM.
//   Each reading is range-checked. Accepted readings go into a DEPTH-deep ring
//   buffer per channel, and the block publishes a moving average of
//   temperature and humidity. It also raises stale_o when no reading has been
//   accepted for STALE_CYC cycles.
//
//   Optional feature: define DHT11_FILTER_SPIKE_EN to enable spike rejection.
//   Once the buffer is full, an in-range sample whose temperature differs from
//   temp_o by more than SPIKE_TH is rejected. The third consecutive spike is
//   treated as a real step change and is accepted.
//
// Ports
//   clk, rst_n     50 MHz clock, asynchronous active-low reset
//   valid_i        one-cycle strobe qualifying temp_i / hum_i
//   temp_i, hum_i  raw integer readings (unsigned, 8 bit)
//   temp_o, hum_o  filtered readings, held between valid_o pulses
//   valid_o        one-cycle strobe, asserted 3 cycles after an accepted valid_i
//   full_o         ring buffer holds DEPTH accepted samples
//   stale_o        no accepted sample for STALE_CYC cycles
//   reject_cnt_o   rejected-sample count, saturates at 255
module dht11_avg_filter #(
    parameter int DEPTH      = 4,
    parameter int LOG2_DEPTH = 2,
    parameter int T_MIN      = 0,
    parameter int T_MAX      = 50,
    parameter int H_MIN      = 20,
    parameter int H_MAX      = 90,
    parameter int STALE_CYC  = 150_000_000,
    parameter int SPIKE_TH   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] temp_i,
    input  logic [7:0] hum_i,
    output logic [7:0] temp_o,
    output logic [7:0] hum_o,
    output logic       valid_o,
    output logic       full_o,
    output logic       stale_o,
    output logic [7:0] reject_cnt_o
);

    localparam int SW = 8 + LOG2_DEPTH;
    localparam int CW = $clog2(STALE_CYC + 1);
    localparam logic [LOG2_DEPTH:0] FULL_CNT  = DEPTH[LOG2_DEPTH:0];
    localparam logic [CW-1:0]       STALE_MAX = STALE_CYC[CW-1:0];

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ACCUM, S_EMIT} state_t;

    state_t                state_q, state_d;
    logic [7:0]            t_lat, h_lat;
    logic [7:0]            t_buf [DEPTH];
    logic [7:0]            h_buf [DEPTH];
    logic [SW-1:0]         t_sum, h_sum, t_sum_d, h_sum_d;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH:0]   count;
    logic [CW-1:0]         stale_cnt;
    logic                  in_range, accept;

`ifdef DHT11_FILTER_SPIKE_EN
    logic [1:0] spike_cnt;
    logic [7:0] t_diff;
    logic       spike;
`endif

    // Comparisons are done as int so a zero lower bound does not turn into
    // a constant-true unsigned compare.
    always_comb begin
        in_range = (int'(t_lat) >= T_MIN) && (int'(t_lat) <= T_MAX) &&
                   (int'(h_lat) >= H_MIN) && (int'(h_lat) <= H_MAX);
`ifdef DHT11_FILTER_SPIKE_EN
        t_diff = (t_lat >= temp_o) ? (t_lat - temp_o) : (temp_o - t_lat);
        spike  = full_o && (int'(t_diff) > SPIKE_TH);
        // Two spikes in a row have already been dropped, so the third is
        // treated as a genuine step change and accepted.
        accept = in_range && (!spike || spike_cnt == 2'd2);
`else
        accept = in_range;
`endif
    end

    // Running sums replace the oldest entry with the new sample. Buffer
    // entries are zero until the first wrap, so the fill phase needs no
    // special case.
    always_comb begin
        t_sum_d = t_sum + SW'(t_lat) - SW'(t_buf[wr_ptr]);
        h_sum_d = h_sum + SW'(h_lat) - SW'(h_buf[wr_ptr]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i) state_d = S_CHECK;
            S_CHECK: state_d = accept ? S_ACCUM : S_IDLE;
            S_ACCUM: state_d = S_EMIT;
            S_EMIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_lat        <= '0;
            h_lat        <= '0;
            t_sum        <= '0;
            h_sum        <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            temp_o       <= '0;
            hum_o        <= '0;
            valid_o      <= 1'b0;
            full_o       <= 1'b0;
            reject_cnt_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                t_buf[i] <= '0;
                h_buf[i] <= '0;
            end
`ifdef DHT11_FILTER_SPIKE_EN
            spike_cnt    <= '0;
`endif
        end else begin
            // Outputs are registered on the way out of S_ACCUM, so valid_o
            // and the new data appear together in S_EMIT.
            valid_o <= (state_q == S_ACCUM);
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        t_lat <= temp_i;
                        h_lat <= hum_i;
                    end
                end
                S_CHECK: begin
                    if (!accept) begin
                        if (reject_cnt_o != 8'hFF) reject_cnt_o <= reject_cnt_o + 1'b1;
`ifdef DHT11_FILTER_SPIKE_EN
                        if (in_range) spike_cnt <= spike_cnt + 1'b1;
`endif
                    end
                end
                S_ACCUM: begin
                    t_sum         <= t_sum_d;
                    h_sum         <= h_sum_d;
                    t_buf[wr_ptr] <= t_lat;
                    h_buf[wr_ptr] <= h_lat;
                    wr_ptr        <= wr_ptr + 1'b1;
                    if (count != FULL_CNT) count <= count + 1'b1;
                    // Average only once the window was already full before
                    // this sample. During fill, pass the newest sample through.
                    if (count == FULL_CNT) begin
                        temp_o <= t_sum_d[SW-1:LOG2_DEPTH];
                        hum_o  <= h_sum_d[SW-1:LOG2_DEPTH];
                    end else begin
                        temp_o <= t_lat;
                        hum_o  <= h_lat;
                    end
                    if (count >= FULL_CNT - 1'b1) full_o <= 1'b1;
`ifdef DHT11_FILTER_SPIKE_EN
                    spike_cnt <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Only an accepted sample clears the stale counter. Rejected samples
    // leave it running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    stale_cnt <= '0;
        else if (state_q == S_ACCUM)   stale_cnt <= '0;
        else if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 1'b1;
    end

    assign stale_o = (stale_cnt == STALE_MAX);

endmodule

// File: tb/tb_dht11_avg_filter.sv
module tb_dht11_avg_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] temp_i = '0;
    logic [7:0] hum_i = '0;
    logic [7:0] temp_o, hum_o, reject_cnt_o;
    logic       valid_o, full_o, stale_o;

    dht11_avg_filter #(.STALE_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .temp_i(temp_i), .hum_i(hum_i),
        .temp_o(temp_o), .hum_o(hum_o), .valid_o(valid_o), .full_o(full_o),
        .stale_o(stale_o), .reject_cnt_o(reject_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: keeps the last DEPTH accepted samples in queues.
    int m_t[$], m_h[$];
    int m_ot, m_oh, m_full, m_rej, m_spk;

    task automatic mreset();
        m_t.delete(); m_h.delete();
        m_ot = 0; m_oh = 0; m_full = 0; m_rej = 0; m_spk = 0;
    endtask

    task automatic mstep(input int t, input int h, output bit v);
        bit acc, was_full;
        int st, sh, d;
        acc = (t >= 0 && t <= 50 && h >= 20 && h <= 90);
`ifdef DHT11_FILTER_SPIKE_EN
        d = (t > m_ot) ? t - m_ot : m_ot - t;
        if (acc && m_full == 1 && d > 5) begin
            m_spk++;
            if (m_spk < 3) acc = 0;
        end
`else
        d = 0;
`endif
        v = acc;
        if (!acc) begin
            if (m_rej < 255) m_rej++;
        end else begin
            m_spk = 0;
            was_full = (m_t.size() == 4);
            m_t.push_back(t); m_h.push_back(h);
            if (m_t.size() > 4) begin
                void'(m_t.pop_front()); void'(m_h.pop_front());
            end
            if (was_full) begin
                st = 0; sh = 0;
                foreach (m_t[i]) begin st += m_t[i]; sh += m_h[i]; end
                m_ot = st / 4; m_oh = sh / 4;
            end else begin
                m_ot = t; m_oh = h;
            end
            m_full = (m_t.size() == 4) ? 1 : 0;
        end
    endtask

    // Send one sample and watch the next four cycles. valid_o must appear
    // exactly once, in the third cycle after valid_i, or not at all.
    task automatic send(input logic [7:0] t, input logic [7:0] h, input bit ev,
                        input int et, input int eh, input int ef, input int er,
                        input string nm);
        int pulses, pos, ot, oh, of;
        pulses = 0; pos = 0; ot = 0; oh = 0; of = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; temp_i = t; hum_i = h;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (valid_o) begin pulses++; pos = k; end
            if (k == 3) begin ot = temp_o; oh = hum_o; of = full_o; end
        end
        chk({nm, " valid_o pulses"}, pulses, ev ? 1 : 0);
        if (ev) chk({nm, " latency"}, pos, 3);
        chk({nm, " temp_o"}, ot, et);
        chk({nm, " hum_o"}, oh, eh);
        chk({nm, " full_o"}, of, ef);
        chk({nm, " reject_cnt_o"}, reject_cnt_o, er);
    endtask

    task automatic msend(input int t, input int h, input string nm);
        bit v;
        mstep(t, h, v);
        send(t[7:0], h[7:0], v, m_ot, m_oh, m_full, m_rej, nm);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] t, h;
        bit         v;
        int         et, eh, ef, er;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int pulses, r, t, h;
        int st_k[4];
        tbl[0]  = '{8'd20, 8'd50, 1'b1, 20, 50, 0, 0};
        tbl[1]  = '{8'd22, 8'd50, 1'b1, 22, 50, 0, 0};
        tbl[2]  = '{8'd24, 8'd50, 1'b1, 24, 50, 0, 0};
        tbl[3]  = '{8'd26, 8'd50, 1'b1, 26, 50, 1, 0};
        tbl[4]  = '{8'd30, 8'd50, 1'b1, 25, 50, 1, 0};
        tbl[5]  = '{8'd60, 8'd50, 1'b0, 25, 50, 1, 1};
        tbl[6]  = '{8'd25, 8'd10, 1'b0, 25, 50, 1, 2};
        tbl[7]  = '{8'd25, 8'd90, 1'b1, 26, 60, 1, 2};
        tbl[8]  = '{8'd25, 8'd91, 1'b0, 26, 60, 1, 3};
        tbl[9]  = '{8'd51, 8'd50, 1'b0, 26, 60, 1, 4};
        tbl[10] = '{8'd26, 8'd20, 1'b1, 26, 52, 1, 4};

        // Reset state and stale timing.
        #12;
        chk("reset outputs", {temp_o, hum_o, valid_o, full_o, stale_o, reject_cnt_o}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (99) @(posedge clk);
        #1 chk("stale_o at 99 idle", stale_o, 0);
        @(posedge clk); #1 chk("stale_o at 100 idle", stale_o, 1);
        send(8'd60, 8'd50, 1'b0, 0, 0, 0, 1, "stale reject");
        chk("stale_o kept after reject", stale_o, 1);
        @(posedge clk); #1;
        valid_i = 1'b1; temp_i = 8'd20; hum_i = 8'd50;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            st_k[k] = stale_o;
        end
        chk("stale_o in S_ACCUM", st_k[2], 1);
        chk("stale_o in S_EMIT", st_k[3], 0);
        chk("stale clear temp_o", temp_o, 20);

        // Fill, average and range vectors.
        do_reset();
        foreach (tbl[i]) send(tbl[i].t, tbl[i].h, tbl[i].v, tbl[i].et, tbl[i].eh,
                              tbl[i].ef, tbl[i].er, $sformatf("vec%0d", i));

        // Reset in the middle of S_ACCUM.
        @(posedge clk); #1;
        valid_i = 1'b1; temp_i = 8'd26; hum_i = 8'd50;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("mid-accum reset outputs", {temp_o, hum_o, valid_o, full_o, stale_o, reject_cnt_o}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin @(negedge clk); if (valid_o) pulses++; end
        chk("no valid_o after reset", pulses, 0);

        // Back-to-back valid_i: only the first sample is taken.
        @(posedge clk); #1;
        valid_i = 1'b1; temp_i = 8'd20; hum_i = 8'd50;
        @(posedge clk); #1;
        temp_i = 8'd30;
        @(posedge clk); #1;
        valid_i = 1'b0;
        pulses = 0;
        repeat (5) begin @(negedge clk); if (valid_o) pulses++; end
        chk("b2b pulses", pulses, 1);
        chk("b2b temp_o", temp_o, 20);
        send(8'd22, 8'd50, 1'b1, 22, 50, 0, 0, "b2b 2nd");
        send(8'd24, 8'd50, 1'b1, 24, 50, 0, 0, "b2b 3rd");
        send(8'd26, 8'd50, 1'b1, 26, 50, 1, 0, "b2b 4th");
        send(8'd30, 8'd50, 1'b1, 25, 50, 1, 0, "b2b 5th");

        // Reject counter saturation.
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            valid_i = 1'b1; temp_i = 8'd200; hum_i = 8'd50;
            @(posedge clk); #1;
            valid_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            if (i == 254) chk("reject_cnt_o at 254", reject_cnt_o, 254);
            if (i == 255) chk("reject_cnt_o at 255", reject_cnt_o, 255);
        end
        chk("reject_cnt_o saturated", reject_cnt_o, 255);

        // Step change of 15 degrees after the window settles at 25.
        do_reset(); mreset();
        for (int i = 0; i < 4; i++) msend(25, 50, $sformatf("fill25_%0d", i));
        for (int i = 0; i < 3; i++) msend(40, 50, $sformatf("step40_%0d", i));
`ifdef DHT11_FILTER_SPIKE_EN
        chk("spike rejects", reject_cnt_o, 2);
`else
        chk("spike rejects", reject_cnt_o, 0);
`endif

        // Random samples against the model.
        do_reset(); mreset();
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) t = m_ot + $urandom_range(0, 16) - 8;
            else        t = $urandom_range(0, 60);
            if (t < 0) t = 0;
            h = $urandom_range(10, 95);
            msend(t, h, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
